// File: rtl/conv_window_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution window controller.
package conv_ctrl_pkg;
  localparam int CNT_W    = 11;
  localparam int STRIDE_1 = 1;
  localparam int STRIDE_2 = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel stream, line-buffer write and window-tag signals of the window controller.
interface conv_window_ctrl_if #(
  parameter int WIDTH = 8
);
  import conv_ctrl_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_ready;
  logic             lb_valid;
  logic [WIDTH-1:0] lb_din;
  logic             win_valid;
  logic [CNT_W-1:0] win_row;
  logic [CNT_W-1:0] win_col;
  logic             win_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, lb_valid, lb_din, win_valid, win_row, win_col, win_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, lb_valid, lb_din, win_valid, win_row, win_col, win_last
  );
endinterface

// File: rtl/conv_window_ctrl_wrap_cnt.sv
// Increment-and-wrap counter; wrap flags the enabled cycle that returns to zero.
module wrap_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en & (cnt == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// Frame controller for a 3-row line buffer: gates the pixel stream and tags
// every transfer that completes a strided 3x3 window with its output coordinate.
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COL_NUM = 128,
  parameter int ROW_NUM = 128,
  parameter int STRIDE  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  conv_window_ctrl_if.slave   bus
);
  localparam int OC = (COL_NUM - 3) / STRIDE + 1;
  localparam int OR = (ROW_NUM - 3) / STRIDE + 1;
  localparam logic [CNT_W-1:0] COL_MAX  = CNT_W'(COL_NUM - 1);
  localparam logic [CNT_W-1:0] ROW_MAX  = CNT_W'(ROW_NUM - 1);
  localparam logic [CNT_W-1:0] WCOL_MAX = CNT_W'(OC - 1);
  localparam logic [CNT_W-1:0] WROW_MAX = CNT_W'(OR - 1);

  state_e           state, state_nxt;
  logic             go, xfer, stride_ok, win_valid;
  logic             col_wrap, row_wrap, win_col_wrap, win_row_wrap;
  logic [CNT_W-1:0] col, row, win_col, win_row;

  assign go   = (state == IDLE) & start & ~abort;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign bus.s_ready  = (state == RUN) & bus.m_ready;
  assign xfer         = bus.s_valid & bus.s_ready;
  assign bus.lb_valid = xfer;
  assign bus.lb_din   = bus.s_data;

  // Stride 2 keeps only windows whose bottom-right corner sits on even row and column.
  assign stride_ok = (STRIDE == STRIDE_2) ? (~row[0] & ~col[0]) : 1'b1;
  assign win_valid = xfer & (row >= CNT_W'(2)) & (col >= CNT_W'(2)) & stride_ok;

  assign bus.win_valid = win_valid;
  assign bus.win_row   = win_row;
  assign bus.win_col   = win_col;
  // The window-row counter wraps exactly on the final window of the frame.
  assign bus.win_last  = win_row_wrap;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (row_wrap) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  wrap_cnt #(.W(CNT_W)) u_col (
    .clk(clk), .rst_n(rst_n), .en(xfer), .clr(go),
    .max(COL_MAX), .cnt(col), .wrap(col_wrap)
  );

  wrap_cnt #(.W(CNT_W)) u_row (
    .clk(clk), .rst_n(rst_n), .en(col_wrap), .clr(go),
    .max(ROW_MAX), .cnt(row), .wrap(row_wrap)
  );

  wrap_cnt #(.W(CNT_W)) u_win_col (
    .clk(clk), .rst_n(rst_n), .en(win_valid), .clr(go),
    .max(WCOL_MAX), .cnt(win_col), .wrap(win_col_wrap)
  );

  wrap_cnt #(.W(CNT_W)) u_win_row (
    .clk(clk), .rst_n(rst_n), .en(win_col_wrap), .clr(go),
    .max(WROW_MAX), .cnt(win_row), .wrap(win_row_wrap)
  );
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench: dut_a is 4x4 stride 1, dut_b is 5x5 stride 2.
module tb_conv_window_ctrl;
  import conv_ctrl_pkg::*;

  localparam int W = 8;

  typedef struct {
    int idx;
    int row;
    int col;
    bit last;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, busy_a, done_a;
  logic start_b = 1'b0, abort_b = 1'b0, busy_b, done_b;

  always #5 clk = ~clk;

  conv_window_ctrl_if #(.WIDTH(W)) ifa ();
  conv_window_ctrl_if #(.WIDTH(W)) ifb ();

  conv_window_ctrl #(.WIDTH(W), .COL_NUM(4), .ROW_NUM(4), .STRIDE(STRIDE_1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .bus(ifa.slave)
  );

  conv_window_ctrl #(.WIDTH(W), .COL_NUM(5), .ROW_NUM(5), .STRIDE(STRIDE_2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .bus(ifb.slave)
  );

  int   checks = 0;
  int   passed = 0;
  win_t qa[$];
  win_t qb[$];
  int   xcnt[2];
  int   dcnt[2];
  int   exp_total[2];
  bit   prev_last[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic mon(input int id, input logic lbv, input logic sv, input logic sready,
                     input logic mrdy, input logic winv, input logic wlast, input logic dn,
                     input logic [CNT_W-1:0] wr, input logic [CNT_W-1:0] wc,
                     input logic [W-1:0] din, input logic [W-1:0] sdat);
    win_t e;
    bit   have;
    if (lbv) begin
      xcnt[id]++;
      chk("lb_din", int'(din), int'(sdat));
    end
    if (sv && !mrdy) begin
      chk("gate_s_ready", int'(sready), 0);
      chk("gate_lb_valid", int'(lbv), 0);
      chk("gate_win_valid", int'(winv), 0);
    end
    if (wlast && !winv) begin
      checks++;
      $display("FAIL win_last_without_valid: dut %0d got 1 expected 0", id);
    end
    if (winv) begin
      have = (id == 0) ? (qa.size() != 0) : (qb.size() != 0);
      if (!have) begin
        checks++;
        $display("FAIL win_unexpected: dut %0d window at transfer %0d expected none", id, xcnt[id]);
      end else begin
        if (id == 0) e = qa.pop_front();
        else         e = qb.pop_front();
        chk("win_idx", xcnt[id], e.idx);
        chk("win_row", int'(wr), e.row);
        chk("win_col", int'(wc), e.col);
        chk("win_last", int'(wlast), int'(e.last));
      end
    end
    if (dn) begin
      dcnt[id]++;
      chk("done_xfer_total", xcnt[id], exp_total[id]);
      chk("done_after_last", int'(prev_last[id]), 1);
      chk("done_s_ready_low", int'(sready), 0);
    end
    prev_last[id] = winv & wlast;
  endtask

  always @(negedge clk) begin
    mon(0, ifa.lb_valid, ifa.s_valid, ifa.s_ready, ifa.m_ready, ifa.win_valid, ifa.win_last,
        done_a, ifa.win_row, ifa.win_col, ifa.lb_din, ifa.s_data);
    mon(1, ifb.lb_valid, ifb.s_valid, ifb.s_ready, ifb.m_ready, ifb.win_valid, ifb.win_last,
        done_b, ifb.win_row, ifb.win_col, ifb.lb_din, ifb.s_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ifa.s_data = W'($urandom);
    ifb.s_data = W'($urandom);
  endtask

  // 4x4 stride 1: windows end at transfers 11,12,15,16.
  task automatic push_s1();
    qa.push_back('{idx: 11, row: 0, col: 0, last: 1'b0});
    qa.push_back('{idx: 12, row: 0, col: 1, last: 1'b0});
    qa.push_back('{idx: 15, row: 1, col: 0, last: 1'b0});
    qa.push_back('{idx: 16, row: 1, col: 1, last: 1'b1});
    exp_total[0] = 16;
  endtask

  // 5x5 stride 2: windows end at transfers 13,15,23,25.
  task automatic push_s2();
    qb.push_back('{idx: 13, row: 0, col: 0, last: 1'b0});
    qb.push_back('{idx: 15, row: 0, col: 1, last: 1'b0});
    qb.push_back('{idx: 23, row: 1, col: 0, last: 1'b0});
    qb.push_back('{idx: 25, row: 1, col: 1, last: 1'b1});
    exp_total[1] = 25;
  endtask

  task automatic start_frame(input int id);
    xcnt[id] = 0;
    if (id == 0) start_a = 1'b1;
    else         start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int id, input int bound, input bit tog);
    int d0;
    int n;
    d0 = dcnt[id];
    n  = 0;
    while (dcnt[id] == d0 && n < bound) begin
      if (tog) ifa.m_ready = ~ifa.m_ready;
      tick();
      n++;
    end
    chk("done_seen", dcnt[id] - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.s_valid = 1'b1; ifa.m_ready = 1'b1; ifa.s_data = '0;
    ifb.s_valid = 1'b0; ifb.m_ready = 1'b1; ifb.s_data = '0;
    for (int i = 0; i < 2; i++) begin
      xcnt[i] = 0; dcnt[i] = 0; exp_total[i] = 0; prev_last[i] = 1'b0;
    end

    #12;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_s_ready", int'(ifa.s_ready), 0);
    chk("rst_lb_valid", int'(ifa.lb_valid), 0);
    chk("rst_win_valid", int'(ifa.win_valid), 0);
    chk("rst_win_last", int'(ifa.win_last), 0);
    chk("rst_win_row", int'(ifa.win_row), 0);
    chk("rst_win_col", int'(ifa.win_col), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_s_ready", int'(ifa.s_ready), 0);
    chk("idle_lb_valid", int'(ifa.lb_valid), 0);

    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    chk("start_abort_stays_idle", int'(busy_a), 0);

    // Full-rate frame, stride 1
    push_s1();
    start_frame(0);
    chk("busy_after_start", int'(busy_a), 1);
    wait_done(0, 100, 1'b0);
    chk("idle_after_done", int'(busy_a), 0);

    // Stride 2 frame
    ifb.s_valid = 1'b1;
    push_s2();
    start_frame(1);
    wait_done(1, 100, 1'b0);
    ifb.s_valid = 1'b0;

    // Back-pressure: m_ready toggles every cycle
    push_s1();
    start_frame(0);
    wait_done(0, 200, 1'b1);
    ifa.m_ready = 1'b1;

    // Abort after 7 transfers, then a clean frame
    start_frame(0);
    repeat (7) tick();
    ifa.s_valid = 1'b0;
    abort_a = 1'b1;
    begin
      int d0;
      d0 = dcnt[0];
      tick();
      abort_a = 1'b0;
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_xfers", xcnt[0], 7);
      repeat (3) tick();
      chk("abort_no_done", dcnt[0] - d0, 0);
    end
    ifa.s_valid = 1'b1;
    push_s1();
    start_frame(0);
    wait_done(0, 100, 1'b0);

    // Async reset mid-row, with start pulses during RUN
    start_frame(0);
    repeat (4) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_s_ready", int'(ifa.s_ready), 0);
    chk("arst_lb_valid", int'(ifa.lb_valid), 0);
    chk("arst_win_valid", int'(ifa.win_valid), 0);
    chk("arst_win_col", int'(ifa.win_col), 0);
    chk("arst_win_row", int'(ifa.win_row), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle_s_ready", int'(ifa.s_ready), 0);
    push_s1();
    start_frame(0);
    repeat (3) begin
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
    end
    wait_done(0, 100, 1'b0);

    repeat (3) tick();
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Frame-level controller that sequences a 3-row line buffer for 3×3 convolution. It accepts a raster pixel stream with a valid/ready handshake and drives the line buffer's `valid_in`/`din`. It tracks the row/column position and flags the transfer cycles that complete a legal 3×3 window under the configured stride, tagging each with its output coordinate. It sits between the pixel source (DMA/feature-map reader) and the line buffer plus convolution PE.

## Interface
Parameters:
- `WIDTH`, 8, pixel width in bits
- `COL_NUM`, 128, pixels per row; legal range 3..2047
- `ROW_NUM`, 128, rows per frame; legal range 3..2047
- `STRIDE`, 1, window stride; legal values 1 or 2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `start`  in  1  pulse; begins a frame, sampled only in IDLE
- `abort`  in  1  synchronous; returns to IDLE from any state, no `done`
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse after the last pixel is accepted
- `s_valid`  in  1  source pixel valid
- `s_ready`  out  1  controller accepts pixel
- `s_data`  in  WIDTH  source pixel
- `m_ready`  in  1  downstream PE can take a window this cycle
- `lb_valid`  out  1  line-buffer write strobe, equal to `s_valid & s_ready`
- `lb_din`  out  WIDTH  line-buffer data, equal to `s_data`
- `win_valid`  out  1  current transfer completes a strided 3×3 window
- `win_row`  out  11  output-map row of the window
- `win_col`  out  11  output-map column of the window
- `win_last`  out  1  qualifies the final window of the frame

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the transfer at (row `ROW_NUM-1`, col `COL_NUM-1`).
  - DONE → IDLE unconditionally after one cycle.
  - `abort` forces IDLE from any state; it has priority over all other transitions.
- Entering RUN clears `col`, `row`, `win_row` and `win_col` to 0.
- Handshake:
  - `s_ready = (state==RUN) & m_ready`, combinational.
  - A transfer is `xfer = s_valid & s_ready`.
  - `s_valid` may be held with no transfer taking place; no data is lost or duplicated.
- Line buffer: `lb_valid = xfer`, `lb_din = s_data`, combinational pass-through. The line buffer never sees a write outside RUN.
- Position counters (11-bit):
  - `col` increments on `xfer` and wraps from `COL_NUM-1` to 0.
  - `row` increments on the wrapping transfer.
- Window condition: `win_valid = xfer & row>=2 & col>=2`, and, when `STRIDE==2`, additionally `row[0]==0 & col[0]==0`.
  - Window rows are row-2..row; window columns are col-2..col.
  - Downstream shift registers capture the columns.
- Output coordinates:
  - `win_col` increments on each `win_valid`.
  - On the last window of a row, `win_col` wraps to 0 and `win_row` increments.
  - Output dimensions are `OC=(COL_NUM-3)/STRIDE+1` and `OR=(ROW_NUM-3)/STRIDE+1`.
  - `win_row` and `win_col` present the value for the current window, i.e. the pre-increment value.
- `win_last = win_valid & win_row==OR-1 & win_col==OC-1`.
- `start` while busy is ignored. Simultaneous `start` and `abort` in IDLE: abort wins and the state stays IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `busy`=0, `done`=0, `s_ready`=0, `lb_valid`=0, `win_valid`=0, `win_last`=0
  - `win_row`=0, `win_col`=0, all counters 0
  - `lb_din` follows `s_data` at all times
- `start` at edge N puts the block in RUN; `s_ready` can be high from cycle N+1.
- `busy` is a registered state decode and rises the cycle after `start`.
- `lb_valid`, `win_valid` and `win_last` are combinational with zero latency relative to `xfer`.
- `done` is high in the single DONE cycle, which follows the last transfer; `s_ready` is low in that cycle.
- When `m_ready` is low, `s_ready` and all strobes are 0 and the counters hold.
- An `rst_n` assertion mid-frame clears everything asynchronously. The line-buffer contents are stale afterwards, and the next frame refills them because the row>=2 gating applies again.

## Structure
- Shared package `conv_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, DONE)
  - `CNT_W=11`
  - `STRIDE_1`, `STRIDE_2` constants
- One sub-module, `wrap_cnt`: a parameterised increment-and-wrap counter with `en`, `clr`, a `max` input and a `wrap` output.
  - Instantiated four times: `col`, `row`, `win_col`, `win_row`.
- The FSM and window decode live in the top level.

## Test plan
- COL=ROW=4, STRIDE=1, `s_valid` and `m_ready` held high → 16 `lb_valid` pulses and 4 `win_valid` pulses on transfers 11, 12, 15, 16. Coordinates are (0,0), (0,1), (1,0), (1,1). `win_last` fires on transfer 16, and `done` rises one cycle later.
- COL=ROW=5, STRIDE=2 → `win_valid` fires on transfers 13, 15, 23, 25 with coordinates (0,0), (0,1), (1,0), (1,1).
- COL=ROW=4, `m_ready` toggled every other cycle → `s_ready` and `lb_valid` are gated, with no transfer while `m_ready`=0. The window sequence and count match scenario 1 exactly.
- `abort` after 7 transfers, then `start` → block returns to IDLE with no `done`. The next frame begins at row=col=0 and yields the full scenario-1 sequence.
- `rst_n` low for 1 cycle mid-row → all outputs are 0 immediately and the state is IDLE. `start` pulses during RUN are ignored, and `s_ready` stays 0 in IDLE even with `s_valid`=1.
